// File: rtl/string_engine_avalon_pkg.sv
// Shared definitions for the string accelerator: operation codes, register map,
// CTRL/STATUS field positions and the byte-limit clamp.
package string_acc_pkg;

    typedef enum logic [1:0] {
        OP_STRLEN = 2'd0,
        OP_STRCMP = 2'd1,
        OP_STRCHR = 2'd2,
        OP_COUNT  = 2'd3
    } op_e;

    localparam int CTRL_OFS   = 0;
    localparam int STATUS_OFS = 1;
    localparam int RESULT_OFS = 2;
    localparam int A_BASE     = 3;

    localparam int CTRL_GO_BIT     = 0;
    localparam int CTRL_OP_LSB     = 1;
    localparam int CTRL_IRQ_EN_BIT = 3;
    localparam int CTRL_CH_LSB     = 8;
    localparam int CTRL_LEN_LSB    = 16;

    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_BUSY_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;

    localparam logic [31:0] NOT_FOUND = 32'hFFFF_FFFF;

    // len==0 means "whole buffer"; anything larger than the buffer is clipped to it.
    function automatic logic [8:0] clamp_limit(input logic [7:0] len, input int max_words);
        logic [8:0] cap;
        cap = 9'(4 * max_words);
        if (len == 8'd0)
            return cap;
        if ({1'b0, len} > cap)
            return cap;
        return {1'b0, len};
    endfunction

endpackage

// File: rtl/string_engine_avalon_if.sv
// Avalon-MM slave bus bundle for the string accelerator, including its interrupt line.
interface string_engine_avalon_if #(
    parameter int ADDR_W = 5
) ();
    logic              chipselect;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;

    modport slave (
        input  chipselect, read, write, address, writedata,
        output readdata, irq
    );

    modport master (
        output chipselect, read, write, address, writedata,
        input  readdata, irq
    );
endinterface

// File: rtl/string_engine_avalon_core.sv
// Byte-serial string engine: walks byte k of A (and B) one per cycle and
// terminates per the selected operation, emitting a one-cycle done pulse with the result.
module string_engine_core
    import string_acc_pkg::*;
#(
    parameter int MAX_WORDS = 8,
    parameter int WIDX      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  op_e             op,
    input  logic [7:0]      ch,
    input  logic [7:0]      len,
    output logic [WIDX-1:0] word_idx,
    input  logic [31:0]     a_word,
    input  logic [31:0]     b_word,
    output logic            busy,
    output logic            done_pulse,
    output logic [31:0]     result
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e     state_reg, state_next;
    op_e        op_reg, op_next;
    logic [7:0] ch_reg, ch_next;
    logic [8:0] lim_reg, lim_next;
    logic [8:0] k_reg, k_next;
    logic [8:0] count_reg, count_next;

    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic [8:0] diff;
    logic       at_lim;
    logic       fin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_STRLEN;
            ch_reg    <= '0;
            lim_reg   <= '0;
            k_reg     <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            ch_reg    <= ch_next;
            lim_reg   <= lim_next;
            k_reg     <= k_next;
            count_reg <= count_next;
        end
    end

    // When k reaches the full capacity the index wraps, but at_lim terminates first.
    assign word_idx = WIDX'(k_reg >> 2);
    assign a_byte   = 8'(a_word >> {k_reg[1:0], 3'b000});
    assign b_byte   = 8'(b_word >> {k_reg[1:0], 3'b000});
    assign diff     = {1'b0, a_byte} - {1'b0, b_byte};
    assign at_lim   = (k_reg == lim_reg);
    assign busy     = (state_reg == S_RUN);

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        ch_next    = ch_reg;
        lim_next   = lim_reg;
        k_next     = k_reg;
        count_next = count_reg;
        fin        = 1'b0;
        result     = '0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    op_next    = op;
                    ch_next    = ch;
                    lim_next   = clamp_limit(len, MAX_WORDS);
                    k_next     = '0;
                    count_next = '0;
                end
            end
            S_RUN: begin
                case (op_reg)
                    OP_STRLEN: begin
                        if (at_lim || a_byte == 8'd0) begin
                            fin    = 1'b1;
                            result = 32'(k_reg);
                        end
                    end
                    OP_STRCMP: begin
                        if (at_lim) begin
                            fin = 1'b1;
                        end else if (a_byte != b_byte) begin
                            fin    = 1'b1;
                            result = {{23{diff[8]}}, diff};
                        end else if (a_byte == 8'd0) begin
                            fin = 1'b1;
                        end
                    end
                    OP_STRCHR: begin
                        // Match is tested before the terminator so ch==0 finds the NUL.
                        if (at_lim) begin
                            fin    = 1'b1;
                            result = NOT_FOUND;
                        end else if (a_byte == ch_reg) begin
                            fin    = 1'b1;
                            result = 32'(k_reg);
                        end else if (a_byte == 8'd0) begin
                            fin    = 1'b1;
                            result = NOT_FOUND;
                        end
                    end
                    default: begin
                        if (at_lim || a_byte == 8'd0) begin
                            fin    = 1'b1;
                            result = 32'(count_reg);
                        end else if (a_byte == ch_reg) begin
                            count_next = count_reg + 9'd1;
                        end
                    end
                endcase
                if (fin)
                    state_next = S_IDLE;
                else
                    k_next = k_reg + 9'd1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign done_pulse = fin;

endmodule

// File: rtl/string_engine_avalon.sv
// Avalon-MM string accelerator top: register decode, A/B string buffers,
// CTRL/STATUS/RESULT registers and the interrupt around the byte-serial core.
module string_engine_avalon
    import string_acc_pkg::*;
#(
    parameter int MAX_WORDS = 8,
    parameter int ADDR_W    = $clog2(2 * MAX_WORDS + 3)
) (
    input  logic                   clk,
    input  logic                   reset,
    string_engine_avalon_if.slave  bus
);

    localparam int WIDX = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    generate
        if (MAX_WORDS < 1 || MAX_WORDS > 64) begin : g_bad_depth
            $error("MAX_WORDS must be in 1..64");
        end
    endgenerate

    logic [31:0] a_mem [MAX_WORDS];
    logic [31:0] b_mem [MAX_WORDS];
    logic [MAX_WORDS-1:0] a_hit;
    logic [MAX_WORDS-1:0] b_hit;

    logic [1:0]  op_reg;
    logic        irq_en_reg;
    logic [7:0]  ch_reg;
    logic [7:0]  len_reg;
    logic        done_reg;
    logic        err_reg;
    logic [31:0] result_reg;
    logic [31:0] readdata_reg;

    logic            busy;
    logic            done_pulse;
    logic [31:0]     core_result;
    logic [WIDX-1:0] word_idx;

    logic        wr_en, rd_en;
    logic        hit_ctrl, hit_status, hit_result, hit_buf;
    logic        go_accept, err_set, buf_wr_ok;
    logic [31:0] rd_word;

    // Write wins when read and write are both asserted.
    assign wr_en      = bus.chipselect & bus.write;
    assign rd_en      = bus.chipselect & bus.read & ~bus.write;
    assign hit_ctrl   = (bus.address == ADDR_W'(CTRL_OFS));
    assign hit_status = (bus.address == ADDR_W'(STATUS_OFS));
    assign hit_result = (bus.address == ADDR_W'(RESULT_OFS));
    assign hit_buf    = (|a_hit) | (|b_hit);
    assign buf_wr_ok  = wr_en & ~busy;
    assign go_accept  = wr_en & hit_ctrl & ~busy & bus.writedata[CTRL_GO_BIT];
    assign err_set    = wr_en & busy & (hit_ctrl | hit_buf);

    generate
        for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_word
            assign a_hit[gi] = (bus.address == ADDR_W'(A_BASE + gi));
            assign b_hit[gi] = (bus.address == ADDR_W'(A_BASE + MAX_WORDS + gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    a_mem[gi] <= '0;
                    b_mem[gi] <= '0;
                end else begin
                    if (buf_wr_ok && a_hit[gi])
                        a_mem[gi] <= bus.writedata;
                    if (buf_wr_ok && b_hit[gi])
                        b_mem[gi] <= bus.writedata;
                end
            end
        end
    endgenerate

    string_engine_core #(
        .MAX_WORDS (MAX_WORDS),
        .WIDX      (WIDX)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .start      (go_accept),
        .op         (op_e'(bus.writedata[CTRL_OP_LSB +: 2])),
        .ch         (bus.writedata[CTRL_CH_LSB +: 8]),
        .len        (bus.writedata[CTRL_LEN_LSB +: 8]),
        .word_idx   (word_idx),
        .a_word     (a_mem[word_idx]),
        .b_word     (b_mem[word_idx]),
        .busy       (busy),
        .done_pulse (done_pulse),
        .result     (core_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_reg     <= '0;
            irq_en_reg <= 1'b0;
            ch_reg     <= '0;
            len_reg    <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            if (wr_en && hit_ctrl && !busy) begin
                op_reg     <= bus.writedata[CTRL_OP_LSB +: 2];
                irq_en_reg <= bus.writedata[CTRL_IRQ_EN_BIT];
                ch_reg     <= bus.writedata[CTRL_CH_LSB +: 8];
                len_reg    <= bus.writedata[CTRL_LEN_LSB +: 8];
            end
            // A completing operation outranks a simultaneous W1C of done.
            if (done_pulse)
                done_reg <= 1'b1;
            else if (go_accept)
                done_reg <= 1'b0;
            else if (wr_en && hit_status && bus.writedata[STATUS_DONE_BIT])
                done_reg <= 1'b0;

            if (err_set)
                err_reg <= 1'b1;
            else if (wr_en && hit_status && bus.writedata[STATUS_ERR_BIT])
                err_reg <= 1'b0;

            if (done_pulse)
                result_reg <= core_result;
            else if (go_accept)
                result_reg <= '0;
        end
    end

    always_comb begin
        rd_word = '0;
        if (hit_ctrl)
            rd_word = {8'd0, len_reg, ch_reg, 4'd0, irq_en_reg, op_reg, 1'b0};
        else if (hit_status)
            rd_word = {29'd0, err_reg, busy, done_reg};
        else if (hit_result)
            rd_word = result_reg;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (a_hit[i])
                rd_word = a_mem[i];
            if (b_hit[i])
                rd_word = b_mem[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            readdata_reg <= '0;
        else if (rd_en)
            readdata_reg <= rd_word;
    end

    assign bus.readdata = readdata_reg;
    assign bus.irq      = done_reg & irq_en_reg;

endmodule

// File: tb/tb_string_engine_avalon.sv
// Directed bench for the string accelerator: one task per scenario, each
// comparing bus-visible results against hand-computed values.
module tb_string_engine_avalon;
    import string_acc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    string_engine_avalon_if #(.ADDR_W(5)) bus ();
    string_engine_avalon_if #(.ADDR_W(3)) bus2 ();

    string_engine_avalon #(.MAX_WORDS(8), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    string_engine_avalon #(.MAX_WORDS(2), .ADDR_W(3)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    localparam logic [4:0] R_CTRL   = 5'd0;
    localparam logic [4:0] R_STATUS = 5'd1;
    localparam logic [4:0] R_RESULT = 5'd2;
    localparam logic [4:0] R_A0     = 5'd3;
    localparam logic [4:0] R_A1     = 5'd4;
    localparam logic [4:0] R_B0     = 5'd11;
    localparam logic [4:0] R_UNMAP  = 5'd31;

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic logic [31:0] ctrl(input logic [1:0] op, input logic [7:0] ch,
                                         input logic [7:0] len, input logic ie, input logic go);
        return {8'd0, len, ch, 4'd0, ie, op, go};
    endfunction

    // All bus helpers start and end on a falling edge and take one cycle each.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic wr2(input logic [2:0] a, input logic [31:0] d);
        bus2.chipselect = 1'b1; bus2.write = 1'b1; bus2.address = a; bus2.writedata = d;
        @(negedge clk);
        bus2.chipselect = 1'b0; bus2.write = 1'b0;
    endtask

    task automatic rd2(input logic [2:0] a, output logic [31:0] d);
        bus2.chipselect = 1'b1; bus2.read = 1'b1; bus2.address = a;
        @(negedge clk);
        bus2.chipselect = 1'b0; bus2.read = 1'b0;
        d = bus2.readdata;
    endtask

    task automatic wait_irq(input int max, output int cycles);
        cycles = 0;
        while (!bus.irq && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic wait_irq2(input int max, output int cycles);
        cycles = 0;
        while (!bus2.irq && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic load_hello();
        wr(R_A0, 32'h6C6C_6548);
        wr(R_A1, 32'h0000_006F);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        if (bus.readdata !== 32'd0) $display("FAIL reset_readdata: got %h expected 00000000", bus.readdata); else pass_cnt++;
        total_cnt++;
        if (bus.irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", bus.irq); else pass_cnt++;
        total_cnt++;
        reset = 1'b1;
        @(negedge clk);
        rd(R_CTRL, v);
        if (v !== 32'd0) $display("FAIL reset_ctrl: got %h expected 00000000", v); else pass_cnt++;
        total_cnt++;
        rd(R_STATUS, v);
        if (v !== 32'd0) $display("FAIL reset_status: got %h expected 00000000", v); else pass_cnt++;
        total_cnt++;
        rd(R_A0, v);
        if (v !== 32'd0) $display("FAIL reset_a0: got %h expected 00000000", v); else pass_cnt++;
        total_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_strlen();
        logic [31:0] v;
        int cyc;
        load_hello();
        rd(R_A0, v);
        if (v !== 32'h6C6C_6548) $display("FAIL a0_readback: got %h expected 6c6c6548", v); else pass_cnt++;
        total_cnt++;
        wr(R_CTRL, ctrl(OP_STRLEN, 8'd0, 8'd0, 1'b1, 1'b1));
        wait_irq(300, cyc);
        if (cyc !== 6) $display("FAIL strlen_latency: got %0d expected 6", cyc); else pass_cnt++;
        total_cnt++;
        rd(R_RESULT, v);
        if (v !== 32'd5) $display("FAIL strlen_result: got %h expected 00000005", v); else pass_cnt++;
        total_cnt++;
        rd(R_STATUS, v);
        if (v !== 32'h1) $display("FAIL strlen_status: got %h expected 00000001", v); else pass_cnt++;
        total_cnt++;
        rd(R_CTRL, v);
        if (v !== 32'h8) $display("FAIL ctrl_readback: got %h expected 00000008", v); else pass_cnt++;
        total_cnt++;
        $display("test_strlen done");
    endtask

    task automatic test_strcmp();
        logic [31:0] v;
        int cyc;
        wr(R_A0, 32'h0063_6261);
        wr(R_B0, 32'h0064_6261);
        wr(R_CTRL, ctrl(OP_STRCMP, 8'd0, 8'd0, 1'b1, 1'b1));
        wait_irq(300, cyc);
        rd(R_RESULT, v);
        if (v !== 32'hFFFF_FFFF) $display("FAIL strcmp_less: got %h expected ffffffff", v); else pass_cnt++;
        total_cnt++;
        if (cyc !== 3) $display("FAIL strcmp_latency: got %0d expected 3", cyc); else pass_cnt++;
        total_cnt++;
        wr(R_A0, 32'h0064_6261);
        wr(R_B0, 32'h0063_6261);
        wr(R_CTRL, ctrl(OP_STRCMP, 8'd0, 8'd0, 1'b1, 1'b1));
        wait_irq(300, cyc);
        rd(R_RESULT, v);
        if (v !== 32'd1) $display("FAIL strcmp_greater: got %h expected 00000001", v); else pass_cnt++;
        total_cnt++;
        wr(R_A0, 32'h0063_6261);
        wr(R_CTRL, ctrl(OP_STRCMP, 8'd0, 8'd0, 1'b1, 1'b1));
        wait_irq(300, cyc);
        rd(R_RESULT, v);
        if (v !== 32'd0 || cyc !== 4) $display("FAIL strcmp_equal: got %h/%0d cycles expected 00000000/4", v, cyc); else pass_cnt++;
        total_cnt++;
        $display("test_strcmp done");
    endtask

    task automatic test_strchr_count();
        logic [31:0] v;
        int cyc;
        load_hello();
        wr(R_CTRL, ctrl(OP_STRCHR, 8'h6C, 8'd0, 1'b1, 1'b1));
        wait_irq(300, cyc);
        rd(R_RESULT, v);
        if (v !== 32'd2 || cyc !== 3) $display("FAIL strchr_l: got %h/%0d cycles expected 00000002/3", v, cyc); else pass_cnt++;
        total_cnt++;
        wr(R_CTRL, ctrl(OP_STRCHR, 8'h7A, 8'd0, 1'b1, 1'b1));
        wait_irq(300, cyc);
        rd(R_RESULT, v);
        if (v !== NOT_FOUND) $display("FAIL strchr_z: got %h expected ffffffff", v); else pass_cnt++;
        total_cnt++;
        wr(R_CTRL, ctrl(OP_STRCHR, 8'h00, 8'd0, 1'b1, 1'b1));
        wait_irq(300, cyc);
        rd(R_RESULT, v);
        if (v !== 32'd5) $display("FAIL strchr_nul: got %h expected 00000005", v); else pass_cnt++;
        total_cnt++;
        wr(R_CTRL, ctrl(OP_COUNT, 8'h6C, 8'd0, 1'b1, 1'b1));
        wait_irq(300, cyc);
        rd(R_RESULT, v);
        if (v !== 32'd2 || cyc !== 6) $display("FAIL count_l: got %h/%0d cycles expected 00000002/6", v, cyc); else pass_cnt++;
        total_cnt++;
        $display("test_strchr_count done");
    endtask

    task automatic test_limit();
        logic [31:0] v;
        int cyc;
        wr(R_CTRL, ctrl(OP_STRLEN, 8'd0, 8'd3, 1'b1, 1'b1));
        wait_irq(300, cyc);
        rd(R_RESULT, v);
        if (v !== 32'd3 || cyc !== 4) $display("FAIL len3_main: got %h/%0d cycles expected 00000003/4", v, cyc); else pass_cnt++;
        total_cnt++;
        wr2(3'd3, 32'h4141_4141);
        wr2(3'd4, 32'h4242_4242);
        wr2(3'd0, ctrl(OP_STRLEN, 8'd0, 8'd0, 1'b1, 1'b1));
        wait_irq2(300, cyc);
        rd2(3'd2, v);
        if (v !== 32'd8 || cyc !== 9) $display("FAIL full_len0: got %h/%0d cycles expected 00000008/9", v, cyc); else pass_cnt++;
        total_cnt++;
        wr2(3'd0, ctrl(OP_STRLEN, 8'd0, 8'd3, 1'b1, 1'b1));
        wait_irq2(300, cyc);
        rd2(3'd2, v);
        if (v !== 32'd3) $display("FAIL small_len3: got %h expected 00000003", v); else pass_cnt++;
        total_cnt++;
        wr2(3'd0, ctrl(OP_STRLEN, 8'd0, 8'd200, 1'b1, 1'b1));
        wait_irq2(300, cyc);
        rd2(3'd2, v);
        if (v !== 32'd8) $display("FAIL small_len200: got %h expected 00000008", v); else pass_cnt++;
        total_cnt++;
        wr2(3'd0, ctrl(OP_COUNT, 8'h41, 8'd0, 1'b1, 1'b1));
        wait_irq2(300, cyc);
        rd2(3'd2, v);
        if (v !== 32'd4) $display("FAIL small_count_a: got %h expected 00000004", v); else pass_cnt++;
        total_cnt++;
        $display("test_limit done");
    endtask

    task automatic test_busy_err();
        logic [31:0] v;
        int cyc;
        wr(R_CTRL, ctrl(OP_STRLEN, 8'd0, 8'd0, 1'b1, 1'b1));
        wr(R_A0, 32'd0);
        wr(R_CTRL, ctrl(OP_STRCHR, 8'h6C, 8'd0, 1'b1, 1'b1));
        rd(R_STATUS, v);
        if (v !== 32'h6) $display("FAIL busy_status: got %h expected 00000006", v); else pass_cnt++;
        total_cnt++;
        wait_irq(300, cyc);
        if (cyc !== 3) $display("FAIL busy_remaining: got %0d expected 3", cyc); else pass_cnt++;
        total_cnt++;
        rd(R_RESULT, v);
        if (v !== 32'd5) $display("FAIL busy_result: got %h expected 00000005", v); else pass_cnt++;
        total_cnt++;
        rd(R_A0, v);
        if (v !== 32'h6C6C_6548) $display("FAIL busy_a0_kept: got %h expected 6c6c6548", v); else pass_cnt++;
        total_cnt++;
        rd(R_CTRL, v);
        if (v !== 32'h8) $display("FAIL busy_ctrl_kept: got %h expected 00000008", v); else pass_cnt++;
        total_cnt++;
        rd(R_STATUS, v);
        if (v !== 32'h5) $display("FAIL done_err_status: got %h expected 00000005", v); else pass_cnt++;
        total_cnt++;
        wr(R_STATUS, 32'h5);
        if (bus.irq !== 1'b0) $display("FAIL irq_after_w1c: got %b expected 0", bus.irq); else pass_cnt++;
        total_cnt++;
        rd(R_STATUS, v);
        if (v !== 32'h0) $display("FAIL w1c_status: got %h expected 00000000", v); else pass_cnt++;
        total_cnt++;
        $display("test_busy_err done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        int cyc;
        wr(R_CTRL, ctrl(OP_STRLEN, 8'd0, 8'd0, 1'b1, 1'b1));
        repeat (5) @(negedge clk);
        wr(R_STATUS, 32'h1);
        if (bus.irq !== 1'b1) $display("FAIL set_beats_clear: got irq %b expected 1", bus.irq); else pass_cnt++;
        total_cnt++;
        wr(R_CTRL, ctrl(OP_STRLEN, 8'd0, 8'd0, 1'b1, 1'b1));
        wait_irq(300, cyc);
        rd(R_RESULT, v);
        if (v !== 32'd5 || cyc !== 6) $display("FAIL back_to_back: got %h/%0d cycles expected 00000005/6", v, cyc); else pass_cnt++;
        total_cnt++;
        $display("test_back_to_back done");
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        int cyc;
        rd(R_A0, v);
        rd(R_UNMAP, v);
        if (v !== 32'd0) $display("FAIL unmapped_read: got %h expected 00000000", v); else pass_cnt++;
        total_cnt++;
        wr(R_CTRL, ctrl(OP_STRLEN, 8'd0, 8'd0, 1'b1, 1'b1));
        wr(R_UNMAP, 32'hFFFF_FFFF);
        wait_irq(300, cyc);
        rd(R_STATUS, v);
        if (v !== 32'h1) $display("FAIL unmapped_no_err: got %h expected 00000001", v); else pass_cnt++;
        total_cnt++;
        rd(R_A0, v);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b1;
        bus.address = R_A1; bus.writedata = 32'h1234_5678;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        if (bus.readdata !== 32'h6C6C_6548) $display("FAIL rw_readdata_hold: got %h expected 6c6c6548", bus.readdata); else pass_cnt++;
        total_cnt++;
        rd(R_A1, v);
        if (v !== 32'h1234_5678) $display("FAIL rw_write_wins: got %h expected 12345678", v); else pass_cnt++;
        total_cnt++;
        wr(R_A1, 32'h0000_006F);
        $display("test_unmapped done");
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic irq_seen;
        int cyc;
        rd(R_A0, v);
        wr(R_CTRL, ctrl(OP_STRLEN, 8'd0, 8'd0, 1'b1, 1'b1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        if (bus.readdata !== 32'd0 || bus.irq !== 1'b0)
            $display("FAIL midrun_reset_outputs: got %h/%b expected 00000000/0", bus.readdata, bus.irq);
        else pass_cnt++;
        total_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        irq_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.irq) irq_seen = 1'b1;
        end
        if (irq_seen !== 1'b0) $display("FAIL midrun_no_irq: got %b expected 0", irq_seen); else pass_cnt++;
        total_cnt++;
        rd(R_STATUS, v);
        if (v !== 32'd0) $display("FAIL midrun_status: got %h expected 00000000", v); else pass_cnt++;
        total_cnt++;
        rd(R_A0, v);
        if (v !== 32'd0) $display("FAIL midrun_a0_cleared: got %h expected 00000000", v); else pass_cnt++;
        total_cnt++;
        load_hello();
        wr(R_CTRL, ctrl(OP_STRLEN, 8'd0, 8'd0, 1'b1, 1'b1));
        wait_irq(300, cyc);
        rd(R_RESULT, v);
        if (v !== 32'd5 || cyc !== 6) $display("FAIL after_reset_run: got %h/%0d cycles expected 00000005/6", v, cyc); else pass_cnt++;
        total_cnt++;
        $display("test_reset_mid done");
    endtask

    initial begin
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.address = '0; bus.writedata = '0;
        bus2.chipselect = 1'b0; bus2.read = 1'b0; bus2.write = 1'b0;
        bus2.address = '0; bus2.writedata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_strlen();
        test_strcmp();
        test_strchr_count();
        test_limit();
        test_busy_err();
        test_back_to_back();
        test_unmapped();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/string_engine_avalon.md
# string_engine_avalon

Parametrised Avalon-MM slave string accelerator for the Nios II system: holds two NUL-terminated string buffers (A, B) and runs a byte-serial engine implementing STRLEN, STRCMP, STRCHR and COUNT. Software loads the strings, writes a control word with `go`, then polls status or waits for `irq`. It supersedes the fixed-size control/A/B slave with a configurable depth, operation select, byte length limit, busy/error status and an interrupt.

## Interface
- `MAX_WORDS`, 8: 32-bit words per string buffer, range 1..64. Capacity is `4*MAX_WORDS` bytes.
- `ADDR_W`, `$clog2(2*MAX_WORDS+3)`: word address width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `chipselect`, `read`, `write`  in  1  Avalon-MM slave strobes.
- `address`  in  ADDR_W  word address: 0 CTRL, 1 STATUS, 2 RESULT, 3..MAX_WORDS+2 A, MAX_WORDS+3..2*MAX_WORDS+2 B.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `irq`  out  1  `done & irq_en`.

## Operation
- Byte k of a string is bits `[8*(k%4)+7 : 8*(k%4)]` of word `k/4`.
- CTRL fields:
  - bit0 `go`: write-1 start, self-clearing, reads 0.
  - [2:1] `op`: 0 STRLEN, 1 STRCMP, 2 STRCHR, 3 COUNT.
  - bit3 `irq_en`.
  - [15:8] `ch`.
  - [23:16] `len`.
  - Other bits read 0.
- STATUS fields:
  - bit0 `done`: sticky; write-1-clear; cleared on go acceptance.
  - bit1 `busy`.
  - bit2 `err`: sticky; write-1-clear.
- RESULT is read-only.
- Limit L = `len==0 ? 4*MAX_WORDS : min(len, 4*MAX_WORDS)`.
- FSM states:
  - IDLE: a write with `go`=1 latches `op`, `ch` and L; clears `done` and RESULT; sets k=0 and count=0; moves to RUN.
  - RUN: examines byte k per cycle. On termination it writes RESULT, sets `done` and returns to IDLE. Otherwise k++.
- Termination per op:
  - STRLEN: A[k]==0 or k==L → k.
  - STRCMP: A[k]!=B[k] → sign-extended 9-bit (A[k]−B[k]). A[k]==0 (equal) or k==L → 0.
  - STRCHR: A[k]==ch → k (checked first, so `ch`=0 finds the terminator). A[k]==0 or k==L → 32'hFFFF_FFFF.
  - COUNT: A[k]==0 or k==L → count. Otherwise count += (A[k]==ch).
- The k==L check precedes byte access; L is never exceeded.
- While busy:
  - Writes to A, B or CTRL are ignored and set `err` (a CTRL `go` write is not accepted).
  - STATUS W1C and all reads remain allowed.
- Unmapped address: read 0, write ignored, no `err`.
- Read and write both asserted: write takes priority; `readdata` holds.

## Timing
- Reset (async assert, sync release):
  - `readdata`, `irq`, CTRL, STATUS, RESULT, A and B = 0; FSM = IDLE.
  - Reset mid-operation aborts with no `done`.
- Read latency: 1 cycle. `readdata` updates only on a read and holds otherwise.
- Write effect: register updated at the accepting edge.
- Engine cycle timing:
  - Go accepted at edge E0; `busy`=1 from E0.
  - Byte k is examined in the cycle ending at edge E(k+1).
  - Termination at byte k: `done`=1, `busy`=0 and RESULT valid after edge E(k+1).
  - `irq` rises the same edge if `irq_en` is set.
- Go-to-done latency: k_term+1 cycles; worst case L+1.
- Set beats clear: a W1C of `done` in the terminating cycle leaves `done`=1.
- Back-to-back: go is accepted the cycle after `busy` falls.

## Structure
- Package `string_acc_pkg`:
  - `op_e` enum.
  - Register offsets CTRL/STATUS/RESULT/A_BASE.
  - CTRL and STATUS bit/field positions.
  - `NOT_FOUND` = 32'hFFFF_FFFF.
- Sub-module `string_engine_core`:
  - Contains the FSM, k, count, L clamp and byte select.
  - Reads the A/B buffers through combinational word ports.
  - Outputs busy, done pulse and result.
- Top level contains the Avalon decode, buffers, CTRL/STATUS and `irq`.
- Elaboration assertion: 1 ≤ MAX_WORDS ≤ 64.

## Test plan
- A="Hello\0", op STRLEN, go → `busy` for 6 cycles; RESULT=5; `done`=1; STATUS reads 0x1.
- A="abc", B="abd", STRCMP → RESULT=0xFFFF_FFFF (−1). Swapped → 1. A=B="abc" → 0.
- A="Hello", STRCHR ch='l' → 2. ch='z' → 0xFFFF_FFFF. ch=0 → 5. COUNT ch='l' → 2.
- MAX_WORDS=2, A fully non-NUL, STRLEN with len=0 → 8 after 9 cycles. len=3 → 3.
- Write A[0] and go during `busy` → ignored, `err`=1, result unaffected. W1C STATUS=0x5 clears `done` and `err`.
- `irq_en`=1, STRLEN → `irq` rises with `done` and falls on W1C. `reset`=0 mid-RUN → all outputs 0, no `irq`; a new go after release runs normally.
